anc_tx_ctrl: RTL and testbench

ANC_TX_CTRL -- requirements
Module: anc_tx_ctrl

---
 rtl/anc_tx_pkg.sv | 26 ++
 rtl/gpio_sync.sv | 23 ++
 rtl/anc_tx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_anc_tx_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/anc_tx_pkg.sv
// rtl/anc_tx_pkg.sv - state encoding and front-panel GPIO masks for anc_tx_ctrl
package anc_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRIG  = 3'd1,
    ST_PRE_P = 3'd2,
    ST_PRE_N = 3'd3,
    ST_GAP   = 3'd4,
    ST_DATA  = 3'd5,
    ST_DONE  = 3'd6
  } tx_state_t;

  localparam logic [11:0] GPIO_TRIG    = 12'h004;
  localparam logic [11:0] GPIO_TXACT   = 12'h040;
  localparam logic [11:0] GPIO_ACK     = 12'h010;
  localparam logic [11:0] GPIO_DONE_IN = 12'h001;
  localparam logic [11:0] GPIO_DDR     = GPIO_TRIG | GPIO_TXACT;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - two-flop synchronizer for asynchronous front-panel inputs
module gpio_sync #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/anc_tx_ctrl.sv
// rtl/anc_tx_ctrl.sv - burst transmit sequencer: tag trigger, +/- preamble, gap, payload symbols
// Optional TRIG acknowledge timeout enabled by defining ANC_TX_TIMEOUT_EN.
module anc_tx_ctrl
  import anc_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NSYMB_WIDTH  = 16,
  parameter int NSYMB        = 512,
  parameter int SYMB_LEN     = 80,
  parameter int SYNC_SIG_N   = 8192,
  parameter int SYNC_AMP     = 16384,
  parameter int TRIG_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [11:0]             fp_gpio_in,
  output logic [11:0]             fp_gpio_out,
  output logic [11:0]             fp_gpio_ddr,
  output logic [DATA_WIDTH-1:0]   itx_out,
  output logic [DATA_WIDTH-1:0]   qtx_out,
  output logic                    tx_valid,
  output logic                    busy,
  output logic                    underrun,
  output logic                    timeout,
  output logic [2:0]              tx_state
);

  // One shared counter times every segment and the trigger wait, so size it for the longest.
  localparam int CNT_W = $clog2(max3(SYNC_SIG_N, SYMB_LEN, TRIG_TIMEOUT) + 1);
  localparam logic [DATA_WIDTH-1:0] AMP_P = DATA_WIDTH'(SYNC_AMP);
  localparam logic [DATA_WIDTH-1:0] AMP_N = DATA_WIDTH'(-SYNC_AMP);

  tx_state_t              state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [NSYMB_WIDTH-1:0] sym_cnt;
  logic [11:0]            gpio_s;
  logic                   ack, done_in, seg_end, sym_end, last_sym, trig_expired;

  gpio_sync #(.WIDTH(12)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (fp_gpio_in),
    .dout  (gpio_s)
  );

  assign ack      = |(gpio_s & GPIO_ACK);
  assign done_in  = |(gpio_s & GPIO_DONE_IN);
  assign seg_end  = (cnt == CNT_W'(SYNC_SIG_N - 1));
  assign sym_end  = (cnt == CNT_W'(SYMB_LEN - 1));
  assign last_sym = (sym_cnt == NSYMB_WIDTH'(NSYMB - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_TRIG;
      ST_TRIG:  if (ack) state_nxt = ST_PRE_P;
                else if (trig_expired) state_nxt = ST_IDLE;
      ST_PRE_P: if (seg_end) state_nxt = ST_PRE_N;
      ST_PRE_N: if (seg_end) state_nxt = ST_GAP;
      ST_GAP:   if (seg_end) state_nxt = ST_DATA;
      ST_DATA:  if (sym_end && last_sym) state_nxt = ST_DONE;
      ST_DONE:  if (done_in) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready    = (state == ST_DATA) && (cnt == '0);
    busy        = (state != ST_IDLE);
    fp_gpio_ddr = GPIO_DDR;
    fp_gpio_out = '0;
    if (state inside {ST_TRIG, ST_PRE_P, ST_PRE_N})
      fp_gpio_out = fp_gpio_out | GPIO_TRIG;
    if (state inside {ST_PRE_P, ST_PRE_N, ST_GAP, ST_DATA})
      fp_gpio_out = fp_gpio_out | GPIO_TXACT;
  end

  assign tx_state = state;

  // Every state change restarts the counters, so each segment counts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      sym_cnt <= '0;
    end else if (state_nxt != state) begin
      cnt     <= '0;
      sym_cnt <= '0;
    end else begin
      case (state)
`ifdef ANC_TX_TIMEOUT_EN
        ST_TRIG:                   cnt <= cnt + CNT_W'(1);
`endif
        ST_PRE_P, ST_PRE_N, ST_GAP: cnt <= cnt + CNT_W'(1);
        ST_DATA: begin
          if (sym_end) begin
            cnt     <= '0;
            sym_cnt <= sym_cnt + NSYMB_WIDTH'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

  // The output register doubles as the symbol latch: loaded at the boundary, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      itx_out  <= '0;
      qtx_out  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_PRE_P: begin itx_out <= AMP_P; qtx_out <= '0; tx_valid <= 1'b1; end
        ST_PRE_N: begin itx_out <= AMP_N; qtx_out <= '0; tx_valid <= 1'b1; end
        ST_GAP:   begin itx_out <= '0;    qtx_out <= '0; tx_valid <= 1'b1; end
        ST_DATA: begin
          tx_valid <= 1'b1;
          if (s_tready) begin
            itx_out <= s_tvalid ? s_tdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            qtx_out <= s_tvalid ? s_tdata[DATA_WIDTH-1:0] : '0;
          end
        end
        default:  begin itx_out <= '0;    qtx_out <= '0; tx_valid <= 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      underrun <= 1'b0;
    else if (state == ST_IDLE && start)
      underrun <= 1'b0;
    else if (s_tready && !s_tvalid)
      underrun <= 1'b1;
  end

`ifdef ANC_TX_TIMEOUT_EN
  assign trig_expired = (cnt == CNT_W'(TRIG_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timeout <= 1'b0;
    else if (state == ST_IDLE && start)
      timeout <= 1'b0;
    else if (state == ST_TRIG && !ack && trig_expired)
      timeout <= 1'b1;
  end
`else
  assign trig_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_anc_tx_ctrl.sv
// tb/tb_anc_tx_ctrl.sv - self-checking bench for anc_tx_ctrl against a sample-stream model
module tb_anc_tx_ctrl;

  localparam int DW    = 16;
  localparam int NSYMB = 4;
  localparam int SLEN  = 80;
  localparam int N     = 8192;
  localparam int AMP   = 16384;
  localparam int TTO   = 100;

  logic          clk = 1'b0;
  logic          reset, start, s_tvalid, s_tready;
  logic [2*DW-1:0] s_tdata;
  logic [11:0]   fp_gpio_in, fp_gpio_out, fp_gpio_ddr;
  logic [DW-1:0] itx_out, qtx_out;
  logic          tx_valid, busy, underrun, timeout;
  logic [2:0]    tx_state;

  anc_tx_ctrl #(
    .DATA_WIDTH(DW), .NSYMB_WIDTH(16), .NSYMB(NSYMB), .SYMB_LEN(SLEN),
    .SYNC_SIG_N(N), .SYNC_AMP(AMP), .TRIG_TIMEOUT(TTO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out),
    .fp_gpio_ddr(fp_gpio_ddr), .itx_out(itx_out), .qtx_out(qtx_out), .tx_valid(tx_valid),
    .busy(busy), .underrun(underrun), .timeout(timeout), .tx_state(tx_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] words[NSYMB];
  bit          vld[NSYMB];
  int          sym_k, first_v, last_v, b6_cnt, b26_cnt;
  logic [31:0] exp_q[$], obs_q[$];
  int          rdy_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, then present the next payload word if the DUT asks.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_valid === 1'b1) begin
      if (obs_q.size() == 0) first_v = cyc;
      last_v = cyc;
      obs_q.push_back({itx_out, qtx_out});
    end
    if (s_tready === 1'b1) rdy_q.push_back(cyc);
    if (fp_gpio_out[6] === 1'b1) b6_cnt++;
    if (fp_gpio_out[6] === 1'b1 && fp_gpio_out[2] === 1'b1) b26_cnt++;
    if (s_tready === 1'b1 && sym_k < NSYMB) begin
      s_tdata  = words[sym_k];
      s_tvalid = vld[sym_k];
      sym_k++;
    end else begin
      s_tdata  = $urandom;
      s_tvalid = 1'($urandom_range(1));
    end
  endtask

  task automatic clear_rec();
    obs_q.delete();
    rdy_q.delete();
    b6_cnt = 0; b26_cnt = 0; sym_k = 0; first_v = 0; last_v = 0;
  endtask

  task automatic start_burst(input int ack_delay);
    clear_rec();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (ack_delay) tick();
    fp_gpio_in = fp_gpio_in | 12'h010;
  endtask

  task automatic run_burst(input string name, input int ack_delay, input bit exp_under);
    int          budget, t, seg, bad_seg;
    int          errs[4];
    int          gap_err;
    logic [15:0] amp_p, amp_n;
    budget = 3 * N + NSYMB * SLEN + ack_delay + 50;
    amp_p  = 16'(AMP);
    amp_n  = 16'(0 - AMP);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back({amp_p, 16'h0000});
    for (int i = 0; i < N; i++) exp_q.push_back({amp_n, 16'h0000});
    for (int i = 0; i < N; i++) exp_q.push_back(32'h0);
    for (int k = 0; k < NSYMB; k++)
      for (int j = 0; j < SLEN; j++) exp_q.push_back(vld[k] ? words[k] : 32'h0);

    start_burst(ack_delay);
    t = 0;
    while (obs_q.size() == 0 && t < budget) begin tick(); t++; end
    while (tx_valid === 1'b1 && t < budget) begin tick(); t++; end
    check({name, "_ends_in_time"}, 64'(t < budget), 64'd1);
    repeat (5) tick();
    check({name, "_done_wait"}, {tx_state, tx_valid, busy, itx_out, qtx_out},
          {3'd6, 1'b0, 1'b1, 32'h0});
    fp_gpio_in = 12'h001;
    t = 0;
    while (busy === 1'b1 && t < 20) begin tick(); t++; end
    check({name, "_back_idle"}, {tx_state, busy, fp_gpio_out}, {3'd0, 1'b0, 12'h000});
    fp_gpio_in = 12'h000;
    check({name, "_underrun"}, 64'(underrun), 64'(exp_under));

    check({name, "_sample_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    check({name, "_tx_valid_contiguous"}, 64'(last_v - first_v + 1), 64'(obs_q.size()));
    errs = '{0, 0, 0, 0};
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      seg = (i < N) ? 0 : (i < 2 * N) ? 1 : (i < 3 * N) ? 2 : 3;
      if (obs_q[i] !== exp_q[i]) errs[seg]++;
    end
    check({name, "_pre_p_errors"}, 64'(errs[0]), 64'd0);
    check({name, "_pre_n_errors"}, 64'(errs[1]), 64'd0);
    check({name, "_gap_errors"},   64'(errs[2]), 64'd0);
    check({name, "_payload_errors"}, 64'(errs[3]), 64'd0);

    check({name, "_tready_pulses"}, 64'(rdy_q.size()), 64'(NSYMB));
    if (rdy_q.size() > 0)
      check({name, "_first_tready_cycle"}, 64'(rdy_q[0]), 64'(first_v - 1 + 3 * N));
    gap_err = 0;
    for (int i = 1; i < rdy_q.size(); i++)
      if (rdy_q[i] - rdy_q[i-1] != SLEN) gap_err++;
    check({name, "_tready_spacing_errors"}, 64'(gap_err), 64'd0);
    check({name, "_txact_cycles"}, 64'(b6_cnt), 64'(3 * N + NSYMB * SLEN));
    check({name, "_trig_with_txact_cycles"}, 64'(b26_cnt), 64'(2 * N));
    bad_seg = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; fp_gpio_in = 12'h000;
    clear_rec();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {itx_out, qtx_out, tx_valid, busy, s_tready, underrun, timeout,
                            fp_gpio_out, tx_state}, '0);
    check("gpio_ddr", 64'(fp_gpio_ddr), 64'h044);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_after_release", {tx_state, busy, tx_valid}, {3'd0, 1'b0, 1'b0});

    // Burst A: every symbol supplied, tag acknowledges after 10 cycles.
    for (int k = 0; k < NSYMB; k++) begin words[k] = $urandom; vld[k] = 1'b1; end
    run_burst("burst_a", 10, 1'b0);

    // Burst B: reset asserted in the middle of the negative preamble.
    start_burst($urandom_range(3, 30));
    t = 0;
    while (tx_state !== 3'd3 && t < 2 * N + 100) begin tick(); t++; end
    check("reach_pre_n", 64'(tx_state), 64'd3);
    repeat (50) tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {itx_out, qtx_out, tx_valid, busy, s_tready, underrun, timeout,
                                  fp_gpio_out, tx_state}, '0);
    fp_gpio_in = 12'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_rec();
    repeat (20) tick();
    check("no_residual_samples", 64'(obs_q.size()), 64'd0);
    check("idle_after_abort", {tx_state, busy}, {3'd0, 1'b0});

    // Burst C: full burst after the abort, payload missing at symbol index 2.
    for (int k = 0; k < NSYMB; k++) begin words[k] = $urandom; vld[k] = (k != 2); end
    run_burst("burst_c", $urandom_range(5, 40), 1'b1);
    repeat (5) tick();
    check("underrun_sticky", 64'(underrun), 64'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("underrun_cleared_on_start", 64'(underrun), 64'd0);
`ifdef ANC_TX_TIMEOUT_EN
    t = 0;
    while (busy === 1'b1 && t < 300) begin t++; tick(); end
    check("trig_timeout_cycles", 64'(t), 64'(TTO));
    check("timeout_exit", {timeout, tx_state, fp_gpio_out}, {1'b1, 3'd0, 12'h000});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("timeout_cleared_on_start", {timeout, tx_state}, {1'b0, 3'd1});
    t = 0;
    while (busy === 1'b1 && t < 300) begin t++; tick(); end
    check("second_timeout", {timeout, tx_state}, {1'b1, 3'd0});
`else
    repeat (300) tick();
    check("trig_waits", {timeout, tx_state, fp_gpio_out, tx_valid}, {1'b0, 3'd1, 12'h004, 1'b0});
    #2;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_after_trig_abort", {tx_state, busy, fp_gpio_out}, {3'd0, 1'b0, 12'h000});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
